// File: rtl/debug_slave_pkg.sv
// Shared types and constants for the virtual-JTAG debug slave: scan/command
// state encodings, default geometry and the status-flag positions in the chain.
package debug_slave_pkg;

    localparam int DEF_DR_W = 38;
    localparam int DEF_IR_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAP   = 2'd1,
        S_SHIFT = 2'd2
    } scan_state_t;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_PEND = 1'b1
    } cmd_state_t;

    // Captured status flags ride in the two top bits of the chain.
    function automatic int ovr_bit(input int dr_w);
        return dr_w - 1;
    endfunction

    function automatic int short_bit(input int dr_w);
        return dr_w - 2;
    endfunction

endpackage

// File: rtl/debug_slave_cmd_reg.sv
// Single-entry valid/ready command holding register loaded by a completed scan.
// Latency: load to cmd_valid 1 cycle; a load while held and not ready is dropped (load_drop).
module debug_slave_cmd_reg
    import debug_slave_pkg::*;
#(
    parameter int DR_W = DEF_DR_W,
    parameter int IR_W = DEF_IR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_vld,
    input  logic [DR_W-1:0]   load_dat,
    input  logic [IR_W-1:0]   load_ch,
    output logic              load_drop,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [IR_W-1:0]   cmd_ch,
    output logic              cmd_action,
    output logic [DR_W-1:0]   jdo
);

    localparam int ACT_BIT = ovr_bit(DR_W);

    cmd_state_t          state_q, state_d;
    logic [DR_W-1:0]     jdo_q, jdo_d;
    logic [IR_W-1:0]     ch_q, ch_d;
    logic                act_q, act_d;
    logic                load_ok;

    // The slot is free when empty, or when the held command leaves this cycle.
    assign load_ok   = load_vld && ((state_q == C_IDLE) || cmd_ready);
    assign load_drop = load_vld && !load_ok;

    always_comb begin
        state_d = state_q;
        jdo_d   = jdo_q;
        ch_d    = ch_q;
        act_d   = act_q;
        if (load_ok) begin
            state_d = C_PEND;
            jdo_d   = load_dat;
            ch_d    = load_ch;
            act_d   = load_dat[ACT_BIT];
        end else if ((state_q == C_PEND) && cmd_ready) begin
            state_d = C_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_IDLE;
            jdo_q   <= '0;
            ch_q    <= '0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            jdo_q   <= jdo_d;
            ch_q    <= ch_d;
            act_q   <= act_d;
        end
    end

    assign cmd_valid  = (state_q == C_PEND);
    assign cmd_ch     = ch_q;
    assign cmd_action = act_q;
    assign jdo        = jdo_q;

endmodule

// File: rtl/debug_slave_scan_ctrl.sv
// Virtual-JTAG debug slave: capture/shift/update scan chain feeding a command handshake.
// Latency: cdr->tdo 1 cycle, udr->cmd_valid 1 cycle; updates while cmd is held and not ready set overrun.
module debug_slave_scan_ctrl
    import debug_slave_pkg::*;
#(
    parameter int DR_W = DEF_DR_W,
    parameter int IR_W = DEF_IR_W,
    parameter int N_CH = 2**IR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IR_W-1:0]      ir_in,
    input  logic                 vs_cdr,
    input  logic                 vs_sdr,
    input  logic                 vs_udr,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic [N_CH*DR_W-1:0] cap_data,
    output logic [DR_W-1:0]      jdo,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [IR_W-1:0]      cmd_ch,
    output logic                 cmd_action,
    output logic                 overrun,
    output logic                 short_scan
);

    localparam int OVR_BIT   = ovr_bit(DR_W);
    localparam int SHORT_BIT = short_bit(DR_W);
    localparam int CNT_W     = $clog2(DR_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_W + 1);

    scan_state_t         scan_q, scan_d;
    logic [DR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovr_q, ovr_d;
    logic                short_q, short_d;

    logic [DR_W-3:0]     cap_sel;
    logic                len_ok;
    logic                load_vld;
    logic                load_drop;

    assign cap_sel  = cap_data[int'(ir_in) * DR_W +: DR_W - 2];
    assign len_ok   = (scan_q != S_IDLE) && (cnt_q == CNT_FULL);
    assign load_vld = vs_udr && len_ok;

    // Strobe priority udr > cdr > sdr keeps flag set and capture-clear exclusive.
    always_comb begin
        scan_d  = scan_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        short_d = short_q;
        if (vs_udr) begin
            scan_d = S_IDLE;
            if (!len_ok) begin
                short_d = 1'b1;
            end else if (load_drop) begin
                ovr_d = 1'b1;
            end
        end else if (vs_cdr) begin
            sr_d[DR_W-3:0]  = cap_sel;
            sr_d[OVR_BIT]   = ovr_q;
            sr_d[SHORT_BIT] = short_q;
            ovr_d           = 1'b0;
            short_d         = 1'b0;
            cnt_d           = '0;
            scan_d          = S_CAP;
        end else if (vs_sdr && (scan_q != S_IDLE)) begin
            sr_d   = {tdi, sr_q[DR_W-1:1]};
            scan_d = S_SHIFT;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q  <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            scan_q  <= scan_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            short_q <= short_d;
        end
    end

    assign tdo        = sr_q[0];
    assign overrun    = ovr_q;
    assign short_scan = short_q;

    debug_slave_cmd_reg #(
        .DR_W (DR_W),
        .IR_W (IR_W)
    ) u_cmd_reg (
        .clk        (clk),
        .reset      (reset),
        .load_vld   (load_vld),
        .load_dat   (sr_q),
        .load_ch    (ir_in),
        .load_drop  (load_drop),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ch     (cmd_ch),
        .cmd_action (cmd_action),
        .jdo        (jdo)
    );

endmodule

// File: tb/tb_debug_slave_scan_ctrl.sv
// Directed and randomized bench for debug_slave_scan_ctrl against a queue-based scan/command model.
module tb_debug_slave_scan_ctrl;

    localparam int DR_W = 38;
    localparam int IR_W = 2;
    localparam int N_CH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [IR_W-1:0]      ir_in;
    logic                 vs_cdr, vs_sdr, vs_udr, tdi;
    logic                 tdo;
    logic [N_CH*DR_W-1:0] cap_data;
    logic [DR_W-1:0]      jdo;
    logic                 cmd_valid, cmd_ready, cmd_action;
    logic [IR_W-1:0]      cmd_ch;
    logic                 overrun, short_scan;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the chain is a bit queue, index 0 is what tdo shows.
    bit              m_chain[$];
    int              m_cnt;
    bit              m_scan;
    bit              m_ovr, m_short, m_pend, m_act;
    logic [DR_W-1:0] m_jdo;
    logic [IR_W-1:0] m_ch;

    always #5 clk = ~clk;

    debug_slave_scan_ctrl #(.DR_W(DR_W), .IR_W(IR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_in      (ir_in),
        .vs_cdr     (vs_cdr),
        .vs_sdr     (vs_sdr),
        .vs_udr     (vs_udr),
        .tdi        (tdi),
        .tdo        (tdo),
        .cap_data   (cap_data),
        .jdo        (jdo),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_action (cmd_action),
        .overrun    (overrun),
        .short_scan (short_scan)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DR_W-1:0] chain_word();
        logic [DR_W-1:0] w;
        for (int i = 0; i < DR_W; i++) w[i] = m_chain[i];
        return w;
    endfunction

    task automatic model_edge();
        bit loaded;
        loaded = 1'b0;
        if (reset) begin
            m_chain = {};
            for (int i = 0; i < DR_W; i++) m_chain.push_back(1'b0);
            m_cnt = 0; m_scan = 0; m_ovr = 0; m_short = 0;
            m_pend = 0; m_jdo = '0; m_ch = '0; m_act = 0;
            return;
        end
        if (vs_udr) begin
            if (m_scan && m_cnt == DR_W) begin
                if (m_pend && !cmd_ready) begin
                    m_ovr = 1'b1;
                end else begin
                    loaded = 1'b1;
                    m_jdo  = chain_word();
                    m_ch   = ir_in;
                    m_act  = m_jdo[DR_W-1];
                end
            end else begin
                m_short = 1'b1;
            end
            m_scan = 1'b0;
        end else if (vs_cdr) begin
            m_chain = {};
            for (int i = 0; i < DR_W - 2; i++) m_chain.push_back(cap_data[int'(ir_in) * DR_W + i]);
            m_chain.push_back(m_short);
            m_chain.push_back(m_ovr);
            m_short = 0; m_ovr = 0; m_cnt = 0; m_scan = 1'b1;
        end else if (vs_sdr && m_scan) begin
            void'(m_chain.pop_front());
            m_chain.push_back(tdi);
            m_cnt++;
        end
        if (loaded) m_pend = 1'b1;
        else if (m_pend && cmd_ready) m_pend = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, then compare every output.
    task automatic cyc(input logic c, input logic s, input logic u, input logic t, input logic r);
        vs_cdr = c; vs_sdr = s; vs_udr = u; tdi = t; cmd_ready = r;
        model_edge();
        @(posedge clk);
        #1;
        check("tdo",        64'(tdo),        64'(m_chain[0]));
        check("cmd_valid",  64'(cmd_valid),  64'(m_pend));
        check("overrun",    64'(overrun),    64'(m_ovr));
        check("short_scan", 64'(short_scan), 64'(m_short));
        check("jdo",        64'(jdo),        64'(m_jdo));
        check("cmd_ch",     64'(cmd_ch),     64'(m_ch));
        check("cmd_action", 64'(cmd_action), 64'(m_act));
    endtask

    task automatic shift_bits(input logic [DR_W+7:0] w, input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, w[i], r);
    endtask

    task automatic rand_cap();
        for (int b = 0; b < N_CH * DR_W; b++) cap_data[b] = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [DR_W+7:0] rand_word();
        logic [DR_W+7:0] w;
        for (int b = 0; b < DR_W + 8; b++) w[b] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    initial begin
        logic [DR_W-1:0] tdo_vec;
        logic [DR_W-1:0] exp_tdo;
        logic [DR_W-1:0] w28;
        logic [DR_W+7:0] wa, wc;
        int p, len;

        exp_tdo = {2'b00, 36'h5_5555_5555};
        w28     = 38'h20_0000_00AB;
        reset = 1'b1; ir_in = '0; cap_data = '0;
        vs_cdr = 0; vs_sdr = 0; vs_udr = 0; tdi = 0; cmd_ready = 0;

        // Reset state.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_flags", 64'({overrun, short_scan}), 64'd0);
        reset = 1'b0;
        cyc(0, 1, 0, 1, 0);

        // Capture channel 1 and read it out LSB first.
        rand_cap();
        ir_in = 2'd1;
        cap_data[DR_W +: DR_W] = 38'h15_5555_5555;
        cyc(1, 0, 0, 0, 0);
        tdo_vec[0] = tdo;
        for (int k = 1; k < DR_W; k++) begin
            cyc(0, 1, 0, 1'($urandom_range(0, 1)), 0);
            tdo_vec[k] = tdo;
        end
        cyc(0, 1, 0, 0, 0);
        check("cap_readout", 64'(tdo_vec), 64'(exp_tdo));

        // Full-length update with ready high.
        ir_in = 2'd2;
        cyc(1, 0, 0, 0, 1);
        shift_bits({8'h00, w28}, DR_W, 1);
        cyc(0, 0, 1, 0, 1);
        check("upd_valid", 64'(cmd_valid), 64'd1);
        check("upd_jdo", 64'(jdo), 64'(w28));
        check("upd_action", 64'(cmd_action), 64'd1);
        check("upd_ch", 64'(cmd_ch), 64'd2);
        cyc(0, 0, 0, 0, 1);
        check("upd_valid_fall", 64'(cmd_valid), 64'd0);

        // One bit short: no command, short_scan reported then cleared by capture.
        cyc(1, 0, 0, 0, 1);
        shift_bits(rand_word(), DR_W - 1, 1);
        cyc(0, 0, 1, 0, 1);
        check("short_set", 64'(short_scan), 64'd1);
        check("short_no_cmd", 64'(cmd_valid), 64'd0);
        cyc(1, 0, 0, 0, 1);
        check("short_clr", 64'(short_scan), 64'd0);
        shift_bits('0, DR_W - 2, 1);
        check("short_in_chain", 64'(tdo), 64'd1);

        // One bit long is also rejected.
        cyc(1, 0, 0, 0, 1);
        shift_bits(rand_word(), DR_W + 1, 1);
        cyc(0, 0, 1, 0, 1);
        check("long_short", 64'(short_scan), 64'd1);

        // Overrun: second command dropped, then reload on same-cycle ready.
        wa = rand_word();
        wc = rand_word();
        cyc(1, 0, 0, 0, 0);
        shift_bits(wa, DR_W, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        shift_bits(rand_word(), DR_W, 0);
        cyc(0, 0, 1, 0, 0);
        check("ovr_set", 64'(overrun), 64'd1);
        check("ovr_jdo_hold", 64'(jdo), 64'(wa[DR_W-1:0]));
        cyc(1, 0, 0, 0, 0);
        shift_bits(wc, DR_W, 0);
        cyc(0, 0, 1, 0, 1);
        check("reload_valid", 64'(cmd_valid), 64'd1);
        check("reload_jdo", 64'(jdo), 64'(wc[DR_W-1:0]));
        cyc(0, 0, 0, 0, 1);
        check("reload_fall", 64'(cmd_valid), 64'd0);

        // Reset mid-handshake and mid-scan.
        cyc(1, 0, 0, 0, 0);
        shift_bits(rand_word(), DR_W, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        shift_bits(rand_word(), 20, 0);
        reset = 1'b1;
        cyc(0, 1, 0, 1, 0);
        check("midrst_outs", 64'({tdo, cmd_valid, cmd_action, overrun, short_scan}), 64'd0);
        check("midrst_jdo", 64'({jdo, cmd_ch}), 64'd0);
        reset = 1'b0;
        shift_bits(rand_word(), 18, 1);
        cyc(0, 0, 1, 0, 1);
        check("midrst_short", 64'(short_scan), 64'd1);
        check("midrst_no_cmd", 64'(cmd_valid), 64'd0);

        // Randomized scans of near-boundary lengths with random ready.
        for (int it = 0; it < 20; it++) begin
            rand_cap();
            ir_in = IR_W'($urandom_range(0, N_CH - 1));
            len = ($urandom_range(0, 3) == 0) ? DR_W - 1 + 2 * int'($urandom_range(0, 1)) : DR_W;
            cyc(1, 0, 0, 0, 1'($urandom_range(0, 1)));
            shift_bits(rand_word(), len, 1'($urandom_range(0, 1)));
            ir_in = IR_W'($urandom_range(0, N_CH - 1));
            cyc(0, 0, 1, 0, 1'($urandom_range(0, 1)));
            cyc(0, 0, 0, 0, 1'($urandom_range(0, 1)));
        end

        // Free-running random strobes, including coincident ones and resets.
        for (int it = 0; it < 400; it++) begin
            p = int'($urandom_range(0, 99));
            if (p == 50) rand_cap();
            ir_in = IR_W'($urandom_range(0, N_CH - 1));
            reset = (p == 99);
            cyc((p < 4) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                ((p < 2) || (p >= 4 && p < 8)) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_slave_scan_ctrl.md
DEBUG_SLAVE_SCAN_CTRL -- requirements
Module: debug_slave_scan_ctrl

Interface
REQ-001 Parameter: DR_W, 38, data-register (scan chain) width in bits, minimum 4.
REQ-002 Parameter: IR_W, 2, instruction width; N_CH = 2**IR_W capture/command channels.
REQ-003 Port: clk  in  1  sole clock; all logic rising-edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: ir_in  in  IR_W  current virtual-JTAG instruction (channel select).
REQ-006 Port: vs_cdr / vs_sdr / vs_udr  in  1 each  capture / shift-one-bit / update strobes, one-cycle pulses.
REQ-007 Port: tdi  in  1  serial data in; tdo  out  1  serial data out.
REQ-008 Port: cap_data  in  N_CH*DR_W  capture sources; channel k occupies bits [k*DR_W +: DR_W].
REQ-009 Port: jdo  out  DR_W  last accepted update word.
REQ-010 Port: cmd_valid  out  1; cmd_ready  in  1; cmd_ch  out  IR_W; cmd_action  out  1 -- command handshake.
REQ-011 Port: overrun  out  1; short_scan  out  1  sticky error flags.

Function
REQ-012 Scan FSM states: S_IDLE, S_CAP, S_SHIFT; strobe priority when coincident: vs_udr > vs_cdr > vs_sdr, lower ones ignored that cycle.
REQ-013 vs_cdr (any state): sr[DR_W-3:0] <= low DR_W-2 bits of cap_data channel ir_in; sr[DR_W-1] <= overrun; sr[DR_W-2] <= short_scan; both flags cleared; bit_cnt <= 0; -> S_CAP.
REQ-014 vs_sdr in S_CAP/S_SHIFT: sr <= {tdi, sr[DR_W-1:1]}; bit_cnt increments, saturating at DR_W+1; -> S_SHIFT; vs_sdr in S_IDLE ignored.
REQ-015 tdo SHALL equal registered sr[0] (no combinational path from tdi).
REQ-016 vs_udr with state S_IDLE or bit_cnt != DR_W: short_scan set, no command, jdo unchanged; -> S_IDLE.
REQ-017 vs_udr with bit_cnt == DR_W and command register free: next cycle jdo <= sr, cmd_ch <= ir_in, cmd_action <= sr[DR_W-1], cmd_valid <= 1; -> S_IDLE.
REQ-018 Command register free = cmd_valid low, or cmd_valid && cmd_ready in the same cycle as vs_udr (accept and reload; cmd_valid stays high).
REQ-019 vs_udr with valid length while register busy (cmd_valid && !cmd_ready): overrun set, new command dropped, held command untouched.
REQ-020 Command FSM C_IDLE/C_PEND: jdo, cmd_ch, cmd_action stable while cmd_valid high; cmd_valid falls the cycle after cmd_valid && cmd_ready without reload.
REQ-021 Latency: vs_udr to cmd_valid = 1 cycle; vs_cdr to first valid tdo = 1 cycle.
REQ-022 Flag set and capture-clear in the same cycle cannot occur (priority); a flag set event wins over no-op.

Reset
REQ-023 reset SHALL force: sr, jdo, bit_cnt, cmd_ch = 0; cmd_valid, cmd_action, tdo, overrun, short_scan = 0; S_IDLE, C_IDLE.
REQ-024 reset mid-scan or mid-handshake SHALL discard the pending command and partial scan with no cmd_valid pulse.

Structure
REQ-025 Package debug_slave_pkg SHALL hold scan/command state enums, flag bit offsets (DR_W-1, DR_W-2) and default DR_W/IR_W.
REQ-026 Sub-module debug_slave_cmd_reg SHALL implement the valid/ready holding register (REQ-017..020); scan FSM and shifter stay in the top.

Verification
REQ-027 DR_W=38, IR_W=2: cdr(ir=1, ch1=38'h15_5555_5555), 38 sdr -> tdo bits LSB-first equal 0x15_5555_5555 low 36 bits then 0,0.
REQ-028 cdr, 38 sdr shifting 38'h20_0000_00AB, udr, cmd_ready=1 -> cmd_valid one cycle after udr, jdo=38'h20_0000_00AB, cmd_action=1, cmd_ch=ir.
REQ-029 cdr, 37 sdr, udr -> no cmd_valid, short_scan=1; next cdr -> sr[36]=1, short_scan cleared.
REQ-030 cmd_ready=0, two valid scans -> second dropped, overrun=1, jdo holds first word; raise cmd_ready and udr same cycle -> reload, cmd_valid stays high.
REQ-031 reset asserted after 20 of 38 sdr, then 18 sdr + udr -> short_scan=1 (S_IDLE), no command, all outputs 0 during reset.
